vectorized_pe_stream: RTL and testbench
=======================================

// Module: vectorized_pe_stream
// PURPOSE
//  Parametrised successor of the SIMD PE vector: SIMD_DEGREE integer lanes, each joining two AXI-S operand
//  streams through its own skid FIFO pair, applying a shared opcode in a LATENCY-deep pipeline.
//  Adds per-input backpressure, output tready stall and an optional per-lane MAC reduction closed on tlast.
//  Sits between the CGRA stream switch and downstream PEs, in place of the ready-less vector PE.
// PARAMETERS
//  SIMD_DEGREE  16  number of lanes
//  DWIDTH       32  lane data width, two's complement
//  FIFO_DEPTH   4   per-operand, per-lane FIFO depth (power of 2, >=2)
//  LATENCY      3   compute pipeline stages (>=1)
// PORTS
//  clk        in   1              clock, all logic rising-edge
//  rst        in   1              synchronous, active-low reset
//  op         in   3              opcode, sampled per lane at fire, carried down the pipe
//  i1_data    in   SIMD*DWIDTH    operand A, lane i = [(i+1)*DWIDTH-1 : i*DWIDTH]
//  i_tvalid1  in   SIMD           operand A valid per lane
//  i_tlast1   in   SIMD           operand A last per lane
//  o_tready1  out  SIMD           operand A ready = lane FIFO A not full
//  i2_data / i_tvalid2 / i_tlast2 / o_tready2   same for operand B
//  o_data     out  SIMD*DWIDTH    result per lane
//  o_tvalid   out  SIMD           result valid per lane
//  o_tlast    out  SIMD           result last per lane
//  i_tready   in   1              downstream ready, vector-wide
// BEHAVIOUR
//  Reset (rst==0 at edge): FIFOs flushed, pipe valids, accumulators, o_tvalid/o_tlast/o_data all 0;
//   o_tready1/2 low during reset, high on the first cycle after release.
//  Push: beat accepted when i_tvalidN[i] & o_treadyN[i]; o_treadyN depends only on FIFO count (no pop
//   look-ahead), so a full FIFO refuses a push even when it pops in the same cycle.
//  adv = i_tready | ~|o_tvalid; stall is global: adv==0 freezes every lane's pipeline and output regs.
//  Lane fire = adv & headA valid & headB valid; pops both heads. Lanes fire independently.
//  Latency: pair pushed at edge t into empty FIFOs with adv high -> on o_data after edge t+1+LATENCY.
//  o_data/o_tvalid/o_tlast stable while o_tvalid[i] & ~i_tready.
//  Ops (32-bit wrap, signed): 000 ADD a+b | 001 SUB a-b | 010 MUL low DWIDTH of a*b | 011 MAX
//   100 NOP: pops, no output beat | 101 MIN | 110 PASS a | 111 MAC (see CONFIGURATION).
//  o_tlast = tlastA | tlastB of the fired pair (ADD..PASS).
//  Mismatched tlast between A and B is not an error; OR rule applies.
// CONFIGURATION
//  VPE_MAC_EN defined: per-lane acc[DWIDTH]; on MAC fire acc <= acc + low(a*b); no output beat
//   unless tlastA|tlastB, then emit acc+a*b with o_tlast=1 and clear acc (clear and next fire same
//   cycle: next fire sees 0). acc held across non-MAC ops and across stall.
//  VPE_MAC_EN undefined: no acc registers; opcode 111 behaves exactly as NOP.
// STRUCTURE
//  Package vpe_pkg: vpe_op_e enum (encodings above), DWIDTH/SIMD defaults, lane_beat_t struct
//   {data, last}, pipe_t struct {data, last, valid}.
//  Sub-module vpe_lane_fifo: sync FIFO (DWIDTH+1 bits, FIFO_DEPTH, count-based full/empty, rst active-low),
//   2*SIMD_DEGREE instances; lane ALU + pipe inline in a generate loop.
// TESTING
//  1 Lane0 A=5,B=7,op=ADD,i_tready=1 -> o_data[0]=12, o_tvalid[0] exactly LATENCY+1 cycles after push.
//  2 Lane3 A only, 5 beats, B idle -> o_tready1[3] low after FIFO_DEPTH accepts, no output; then B 5 beats
//    -> 5 results in order, none lost.
//  3 op=MUL 0x10000*0x10000 -> 0; op=MAX -1 vs 1 -> 1; op=NOP -> no o_tvalid, FIFOs drained.
//  4 i_tready=0 for 10 cycles with results pending -> o_data frozen, no beat dropped/duplicated on release.
//  5 MAC (VPE_MAC_EN) pairs (1,2),(3,4),(5,6,tlast) -> single beat 44, o_tlast=1; next packet starts at 0;
//    without macro -> no output.
//  6 rst=0 mid-stream with full FIFOs -> next cycle all o_tvalid=0, restart yields only new-data results.

Source files
------------

// File: rtl/vpe_pkg.sv
// Shared types for the vectorized stream PE: opcode encoding, lane beat and pipe payloads.
// VPE_MAC_EN selects whether opcode 111 accumulates (defined) or behaves as NOP (undefined).
package vpe_pkg;

   localparam int unsigned VPE_DWIDTH = 32;
   localparam int unsigned VPE_SIMD   = 16;

`ifdef VPE_MAC_EN
   localparam bit VPE_MAC_ON = 1'b1;
`else
   localparam bit VPE_MAC_ON = 1'b0;
`endif

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_MUL  = 3'b010,
      OP_MAX  = 3'b011,
      OP_NOP  = 3'b100,
      OP_MIN  = 3'b101,
      OP_PASS = 3'b110,
      OP_MAC  = 3'b111
   } vpe_op_e;

   typedef struct packed {
      logic [VPE_DWIDTH-1:0] data;
      logic                  last;
   } lane_beat_t;

   typedef struct packed {
      logic [VPE_DWIDTH-1:0] data;
      logic                  last;
      logic                  valid;
   } pipe_t;

   // Whether a fired pair produces an output beat; MAC only emits on packet end.
   function automatic logic op_emits(input vpe_op_e op, input logic last);
      logic emit;
      case (op)
         OP_NOP:  emit = 1'b0;
         OP_MAC:  emit = VPE_MAC_ON & last;
         default: emit = 1'b1;
      endcase
      return emit;
   endfunction

endpackage

// File: rtl/vpe_lane_fifo.sv
// Per-lane, per-operand synchronous FIFO with count-based full/empty and active-low sync reset.
module vpe_lane_fifo #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Storage is not reset; only pointers and count define occupancy.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/vectorized_pe_stream.sv
// SIMD stream PE: each lane joins two AXI-S operand streams via skid FIFOs and applies a shared opcode
// through a LATENCY-deep pipe under a vector-wide output stall. VPE_MAC_EN adds per-lane MAC reduction.
module vectorized_pe_stream
   import vpe_pkg::*;
#(
   parameter int unsigned SIMD_DEGREE = VPE_SIMD,
   parameter int unsigned DWIDTH      = VPE_DWIDTH,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned LATENCY     = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [2:0]                    op,
   input  logic [SIMD_DEGREE*DWIDTH-1:0] i1_data,
   input  logic [SIMD_DEGREE-1:0]        i_tvalid1,
   input  logic [SIMD_DEGREE-1:0]        i_tlast1,
   output logic [SIMD_DEGREE-1:0]        o_tready1,
   input  logic [SIMD_DEGREE*DWIDTH-1:0] i2_data,
   input  logic [SIMD_DEGREE-1:0]        i_tvalid2,
   input  logic [SIMD_DEGREE-1:0]        i_tlast2,
   output logic [SIMD_DEGREE-1:0]        o_tready2,
   output logic [SIMD_DEGREE*DWIDTH-1:0] o_data,
   output logic [SIMD_DEGREE-1:0]        o_tvalid,
   output logic [SIMD_DEGREE-1:0]        o_tlast,
   input  logic                          i_tready
);

   localparam int unsigned BEAT_W = $bits(lane_beat_t);

   logic ready_q;
   logic adv;

   // Pipeline moves when downstream accepts or nothing is being presented.
   assign adv = i_tready | ~|o_tvalid;

   // Holds input readiness low through reset and for the reset edge itself.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
      end
   end

   for (genvar i = 0; i < SIMD_DEGREE; i++) begin : g_lane
      lane_beat_t        a_in;
      lane_beat_t        b_in;
      lane_beat_t        a_head;
      lane_beat_t        b_head;
      logic              a_full;
      logic              a_empty;
      logic              b_full;
      logic              b_empty;
      logic              fire;
      logic [DWIDTH-1:0] s0_a;
      logic [DWIDTH-1:0] s0_b;
      logic [DWIDTH-1:0] prod;
      logic [DWIDTH-1:0] mac_sum;
      vpe_op_e           s0_op;
      logic              s0_last;
      logic              s0_valid;
      pipe_t             alu;
      pipe_t             pipe_q [LATENCY];

      assign a_in.data = i1_data[i*DWIDTH +: DWIDTH];
      assign a_in.last = i_tlast1[i];
      assign b_in.data = i2_data[i*DWIDTH +: DWIDTH];
      assign b_in.last = i_tlast2[i];

      assign o_tready1[i] = ready_q & ~a_full;
      assign o_tready2[i] = ready_q & ~b_full;

      vpe_lane_fifo #(
         .WIDTH (BEAT_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo_a (
         .clk   (clk),
         .rst   (rst),
         .push  (i_tvalid1[i] & o_tready1[i]),
         .wdata (a_in),
         .pop   (fire),
         .rdata (a_head),
         .full  (a_full),
         .empty (a_empty)
      );

      vpe_lane_fifo #(
         .WIDTH (BEAT_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo_b (
         .clk   (clk),
         .rst   (rst),
         .push  (i_tvalid2[i] & o_tready2[i]),
         .wdata (b_in),
         .pop   (fire),
         .rdata (b_head),
         .full  (b_full),
         .empty (b_empty)
      );

      assign fire = adv & ~a_empty & ~b_empty;

      // Operand capture stage: joins both heads with the opcode present at fire.
      always_ff @(posedge clk) begin
         if (!rst) begin
            s0_valid <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
            s0_op    <= OP_NOP;
            s0_last  <= 1'b0;
         end else if (adv) begin
            s0_valid <= fire;
            if (fire) begin
               s0_a    <= a_head.data;
               s0_b    <= b_head.data;
               s0_op   <= vpe_op_e'(op);
               s0_last <= a_head.last | b_head.last;
            end
         end
      end

      assign prod = s0_a * s0_b;

`ifdef VPE_MAC_EN
      logic [DWIDTH-1:0] acc_q;

      assign mac_sum = acc_q + prod;

      // Accumulator consumes each MAC pair exactly once, on the edge it leaves the capture stage.
      always_ff @(posedge clk) begin
         if (!rst) begin
            acc_q <= '0;
         end else if (adv && s0_valid && (s0_op == OP_MAC)) begin
            acc_q <= s0_last ? '0 : mac_sum;
         end
      end
`else
      assign mac_sum = '0;
`endif

      always_comb begin
         alu = '0;
         case (s0_op)
            OP_ADD:  alu.data = s0_a + s0_b;
            OP_SUB:  alu.data = s0_a - s0_b;
            OP_MUL:  alu.data = prod;
            OP_MAX:  alu.data = ($signed(s0_a) > $signed(s0_b)) ? s0_a : s0_b;
            OP_MIN:  alu.data = ($signed(s0_a) < $signed(s0_b)) ? s0_a : s0_b;
            OP_PASS: alu.data = s0_a;
            OP_MAC:  alu.data = mac_sum;
            default: alu.data = '0;
         endcase
         alu.last  = s0_last;
         alu.valid = s0_valid & op_emits(s0_op, s0_last);
      end

      // Compute pipe; the last stage is the lane's output register.
      always_ff @(posedge clk) begin
         if (!rst) begin
            for (int k = 0; k < LATENCY; k++) begin
               pipe_q[k] <= '0;
            end
         end else if (adv) begin
            pipe_q[0] <= alu;
            for (int k = 1; k < LATENCY; k++) begin
               pipe_q[k] <= pipe_q[k-1];
            end
         end
      end

      assign o_data[i*DWIDTH +: DWIDTH] = pipe_q[LATENCY-1].data;
      assign o_tvalid[i]                = pipe_q[LATENCY-1].valid;
      assign o_tlast[i]                 = pipe_q[LATENCY-1].last;
   end

endmodule

// File: tb/tb_vectorized_pe_stream.sv
// Scoreboard bench for vectorized_pe_stream: per-lane expected queues filled from an arithmetic model,
// drained by a negedge monitor on every accepted output beat. Honours VPE_MAC_EN.
module tb_vectorized_pe_stream;

   localparam int S     = 16;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int LAT   = 3;

`ifdef VPE_MAC_EN
   localparam bit MAC_ON = 1'b1;
`else
   localparam bit MAC_ON = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } tb_beat_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [2:0]      op;
   logic [S*DW-1:0] i1_data;
   logic [S-1:0]    i_tvalid1;
   logic [S-1:0]    i_tlast1;
   logic [S-1:0]    o_tready1;
   logic [S*DW-1:0] i2_data;
   logic [S-1:0]    i_tvalid2;
   logic [S-1:0]    i_tlast2;
   logic [S-1:0]    o_tready2;
   logic [S*DW-1:0] o_data;
   logic [S-1:0]    o_tvalid;
   logic [S-1:0]    o_tlast;
   logic            i_tready;

   tb_beat_t      qa    [S][$];
   tb_beat_t      qb    [S][$];
   tb_beat_t      exp_q [S][$];
   logic [DW-1:0] acc   [S];

   int n_vec = 0;
   int n_err = 0;
   bit gaps;
   int tready_mode;

   vectorized_pe_stream #(
      .SIMD_DEGREE (S),
      .DWIDTH      (DW),
      .FIFO_DEPTH  (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .op        (op),
      .i1_data   (i1_data),
      .i_tvalid1 (i_tvalid1),
      .i_tlast1  (i_tlast1),
      .o_tready1 (o_tready1),
      .i2_data   (i2_data),
      .i_tvalid2 (i_tvalid2),
      .i_tlast2  (i_tlast2),
      .o_tready2 (o_tready2),
      .o_data    (o_data),
      .o_tvalid  (o_tvalid),
      .o_tlast   (o_tlast),
      .i_tready  (i_tready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] req);
      n_vec++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   // Reference: plain signed 32-bit arithmetic on the pair, MAC kept as a running sum per lane.
   task automatic model(input int lane, input logic [DW-1:0] a, input logic la,
                        input logic [DW-1:0] b, input logic lb);
      logic [DW-1:0] r;
      logic [DW-1:0] p;
      logic          emit;
      p    = a * b;
      r    = '0;
      emit = 1'b1;
      case (op)
         3'd0: r = a + b;
         3'd1: r = a - b;
         3'd2: r = p;
         3'd3: r = ($signed(a) > $signed(b)) ? a : b;
         3'd5: r = ($signed(a) < $signed(b)) ? a : b;
         3'd6: r = a;
         3'd7: begin
            emit = 1'b0;
            if (MAC_ON) begin
               acc[lane] = acc[lane] + p;
               if (la | lb) begin
                  r         = acc[lane];
                  acc[lane] = '0;
                  emit      = 1'b1;
               end
            end
         end
         default: emit = 1'b0;
      endcase
      if (emit) exp_q[lane].push_back('{data: r, last: la | lb});
   endtask

   task automatic add_pair(input int lane, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic la, input logic lb);
      qa[lane].push_back('{data: a, last: la});
      qb[lane].push_back('{data: b, last: lb});
      model(lane, a, la, b, lb);
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] v;
      if ($urandom_range(3) == 0) v = DW'($urandom_range(16)) - DW'(8);
      else                        v = DW'($urandom);
      return v;
   endfunction

   // One clock of AXI-S source behaviour: retire accepted beats, present next ones, set downstream ready.
   task automatic drive_cycle();
      logic [S-1:0] acc1;
      logic [S-1:0] acc2;
      @(negedge clk);
      acc1 = i_tvalid1 & o_tready1;
      acc2 = i_tvalid2 & o_tready2;
      @(posedge clk);
      #1;
      for (int i = 0; i < S; i++) begin
         if (acc1[i]) begin
            qa[i].delete(0);
            i_tvalid1[i] = 1'b0;
         end
         if (acc2[i]) begin
            qb[i].delete(0);
            i_tvalid2[i] = 1'b0;
         end
         if (!i_tvalid1[i] && qa[i].size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
            i_tvalid1[i]          = 1'b1;
            i1_data[i*DW +: DW]   = qa[i][0].data;
            i_tlast1[i]           = qa[i][0].last;
         end
         if (!i_tvalid2[i] && qb[i].size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
            i_tvalid2[i]          = 1'b1;
            i2_data[i*DW +: DW]   = qb[i][0].data;
            i_tlast2[i]           = qb[i][0].last;
         end
      end
      case (tready_mode)
         0:       i_tready = 1'b1;
         1:       i_tready = ($urandom_range(3) != 0);
         default: i_tready = 1'b0;
      endcase
   endtask

   function automatic bit pending();
      bit p = 1'b0;
      for (int i = 0; i < S; i++) begin
         if (qa[i].size() > 0 || qb[i].size() > 0 || exp_q[i].size() > 0) p = 1'b1;
      end
      return p;
   endfunction

   task automatic drain();
      int n;
      int saved;
      n = 0;
      while (pending() && n < 3000) begin
         drive_cycle();
         n++;
      end
      check("drain_pending", 32'(pending()), 32'd0);
      saved       = tready_mode;
      tready_mode = 0;
      repeat (2 * DEPTH + LAT + 4) drive_cycle();
      tready_mode = saved;
   endtask

   task automatic clear_model();
      for (int i = 0; i < S; i++) begin
         qa[i].delete();
         qb[i].delete();
         exp_q[i].delete();
         acc[i] = '0;
      end
      i_tvalid1 = '0;
      i_tvalid2 = '0;
   endtask

   // Monitor: every beat the DUT hands downstream must match the lane's next expected beat.
   always @(negedge clk) begin
      if (rst && i_tready) begin
         for (int i = 0; i < S; i++) begin
            if (o_tvalid[i]) begin
               n_vec++;
               if (exp_q[i].size() == 0) begin
                  n_err++;
                  $display("FAIL lane%0d_out: got unexpected beat data=%h last=%b, required no beat",
                           i, o_data[i*DW +: DW], o_tlast[i]);
               end else begin
                  tb_beat_t e;
                  e = exp_q[i].pop_front();
                  if (o_data[i*DW +: DW] !== e.data || o_tlast[i] !== e.last) begin
                     n_err++;
                     $display("FAIL lane%0d_out: got data=%h last=%b, required data=%h last=%b",
                              i, o_data[i*DW +: DW], o_tlast[i], e.data, e.last);
                  end
               end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] ta [5];
      logic [DW-1:0] tbv [5];

      rst = 1'b0;  op = 3'd0;  i_tready = 1'b0;
      i1_data = '0; i2_data = '0; i_tvalid1 = '0; i_tvalid2 = '0; i_tlast1 = '0; i_tlast2 = '0;
      gaps = 1'b0; tready_mode = 0;
      clear_model();

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tvalid", 32'(o_tvalid), 32'd0);
      check("rst_tready1", 32'(o_tready1), 32'd0);
      check("rst_tready2", 32'(o_tready2), 32'd0);
      check("rst_data0", o_data[DW-1:0], 32'd0);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      check("rel_tready1", 32'(o_tready1), 32'h0000_FFFF);
      check("rel_tready2", 32'(o_tready2), 32'h0000_FFFF);

      // Single ADD pair, exact latency
      op = 3'd0; i_tready = 1'b1;
      exp_q[0].push_back('{data: 32'd12, last: 1'b0});
      i1_data[DW-1:0] = 32'd5; i2_data[DW-1:0] = 32'd7;
      i_tvalid1[0] = 1'b1; i_tvalid2[0] = 1'b1;
      @(posedge clk); #1;
      i_tvalid1[0] = 1'b0; i_tvalid2[0] = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
         @(posedge clk); #1;
         check($sformatf("lat_tvalid_edge%0d", k), 32'(o_tvalid[0]), 32'(k == LAT + 1));
      end
      drain();

      // Operand A alone fills its FIFO, then B releases all pairs in order
      op = 3'd0; gaps = 1'b0; tready_mode = 0;
      for (int j = 0; j < 5; j++) begin
         ta[j]  = rnd_data();
         tbv[j] = rnd_data();
         qa[3].push_back('{data: ta[j], last: 1'b0});
      end
      repeat (10) drive_cycle();
      check("bp_tready1_lane3", 32'(o_tready1[3]), 32'd0);
      check("bp_accepted", 32'(qa[3].size()), 32'd1);
      check("bp_no_output", 32'(o_tvalid), 32'd0);
      for (int j = 0; j < 5; j++) begin
         qb[3].push_back('{data: tbv[j], last: 1'b0});
         model(3, ta[j], 1'b0, tbv[j], 1'b0);
      end
      drain();

      // MUL wrap, signed MAX, NOP drains without output
      op = 3'd2; add_pair(1, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0); drain();
      op = 3'd3; add_pair(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1); drain();
      op = 3'd4; gaps = 1'b1;
      for (int i = 0; i < S; i++) begin
         for (int j = 0; j < 6; j++) add_pair(i, rnd_data(), rnd_data(), 1'b0, 1'b0);
      end
      drain();
      check("nop_tvalid", 32'(o_tvalid), 32'd0);
      check("nop_tready1", 32'(o_tready1), 32'h0000_FFFF);
      check("nop_tready2", 32'(o_tready2), 32'h0000_FFFF);

      // Output stall holds the presented beat on every lane
      op = 3'd0; gaps = 1'b0; tready_mode = 2; i_tready = 1'b0;
      for (int i = 0; i < S; i++) begin
         for (int j = 0; j < 4; j++) add_pair(i, rnd_data(), rnd_data(), 1'(j == 3), 1'b0);
      end
      repeat (10) drive_cycle();
      check("stall_tvalid", 32'(o_tvalid), 32'h0000_FFFF);
      for (int i = 0; i < S; i++) begin
         check($sformatf("stall_hold_lane%0d", i), o_data[i*DW +: DW], exp_q[i][0].data);
      end
      tready_mode = 1;
      drain();

      // MAC packet (1,2),(3,4),(5,6,last) then a fresh packet
      op = 3'd7; tready_mode = 0;
      add_pair(2, 32'd1, 32'd2, 1'b0, 1'b0);
      add_pair(2, 32'd3, 32'd4, 1'b0, 1'b0);
      add_pair(2, 32'd5, 32'd6, 1'b1, 1'b0);
      add_pair(2, 32'd2, 32'd3, 1'b0, 1'b1);
      drain();

      // Randomized phases, one opcode per phase
      for (int p = 0; p < 10; p++) begin
         op = 3'($urandom_range(7)); gaps = 1'b1; tready_mode = 1;
         for (int i = 0; i < S; i++) begin
            int n;
            n = $urandom_range(7, 2);
            for (int j = 0; j < n; j++) begin
               add_pair(i, rnd_data(), rnd_data(), 1'($urandom_range(3) == 0), 1'($urandom_range(5) == 0));
            end
         end
         drain();
      end

      // Reset with full FIFOs and pending results
      op = 3'd1; gaps = 1'b0; tready_mode = 2; i_tready = 1'b0;
      for (int i = 0; i < S; i++) begin
         for (int j = 0; j < 8; j++) add_pair(i, rnd_data(), rnd_data(), 1'b0, 1'b0);
      end
      repeat (12) drive_cycle();
      check("pre_rst_full", 32'(o_tready1), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_tvalid", 32'(o_tvalid), 32'd0);
      check("mid_rst_tready1", 32'(o_tready1), 32'd0);
      check("mid_rst_tready2", 32'(o_tready2), 32'd0);
      clear_model();
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      check("post_rst_tready1", 32'(o_tready1), 32'h0000_FFFF);
      check("post_rst_tvalid", 32'(o_tvalid), 32'd0);
      op = 3'd0; gaps = 1'b1; tready_mode = 1;
      for (int i = 0; i < S; i++) begin
         for (int j = 0; j < 5; j++) add_pair(i, rnd_data(), rnd_data(), 1'($urandom_range(3) == 0), 1'b0);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
